// File: rtl/fpu_mem_arbiter_pkg.sv
// Shared types and default widths for the CPU/FPU data-memory arbiter.
package fpu_mem_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned STRB_W_DEF   = DATA_W_DEF / 8;
    localparam int unsigned MAX_WAIT_DEF = 8;
    localparam int unsigned MAX_LOCK_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_FPU  = 2'd2
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [STRB_W_DEF-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/fpu_mem_arbiter_if.sv
// Bundle of both requester ports and the memory-macro port; slave = arbiter view.
interface fpu_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [STRB_W-1:0] cpu_wstrb;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              fpu_req;
    logic              fpu_we;
    logic              fpu_lock;
    logic [ADDR_W-1:0] fpu_addr;
    logic [DATA_W-1:0] fpu_wdata;
    logic [STRB_W-1:0] fpu_wstrb;
    logic              fpu_gnt;
    logic              fpu_rvalid;
    logic [DATA_W-1:0] fpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  fpu_req, fpu_we, fpu_lock, fpu_addr, fpu_wdata, fpu_wstrb,
        output fpu_gnt, fpu_rvalid, fpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output fpu_req, fpu_we, fpu_lock, fpu_addr, fpu_wdata, fpu_wstrb,
        input  fpu_gnt, fpu_rvalid, fpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/fpu_mem_arbiter_pick.sv
// Combinational winner selection: FPU lock, then starvation, then pointer-first base policy.
module mem_arb_pick
    import fpu_mem_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_fpu_req,
    input  logic   i_locked,
    input  logic   i_cpu_starve,
    input  logic   i_fpu_starve,
    input  owner_e i_rr_ptr,
    output owner_e o_winner
);

    always_comb begin
        o_winner = OWN_NONE;
        if (i_locked && i_fpu_req) begin
            o_winner = OWN_FPU;
        end else if (i_cpu_starve && i_cpu_req) begin
            o_winner = OWN_CPU;
        end else if (i_fpu_starve && i_fpu_req) begin
            o_winner = OWN_FPU;
        end else if (i_rr_ptr == OWN_FPU) begin
            if (i_fpu_req)      o_winner = OWN_FPU;
            else if (i_cpu_req) o_winner = OWN_CPU;
        end else begin
            if (i_cpu_req)      o_winner = OWN_CPU;
            else if (i_fpu_req) o_winner = OWN_FPU;
        end
    end

endmodule

// File: rtl/fpu_mem_arbiter.sv
// CPU/FPU single-port data-memory arbiter with anti-starvation and FPU burst lock.
// FPU_MEM_ARB_RR_EN selects round-robin base policy; default is fixed CPU-first.
module fpu_mem_arbiter
    import fpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic                clock,
    input  logic                reset,
    fpu_mem_arbiter_if.slave    bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } sel_t;

    owner_e            r_rd_owner;
    logic [WAIT_W-1:0] r_cpu_wait;
    logic [WAIT_W-1:0] r_fpu_wait;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_locked;
    logic              r_force_cpu;

    owner_e            w_pick;
    owner_e            w_win;
    owner_e            w_rr_ptr;
    logic              w_cpu_acc;
    logic              w_fpu_acc;
    logic              w_cpu_starve;
    logic              w_fpu_starve;
    sel_t              w_sel;

`ifdef FPU_MEM_ARB_RR_EN
    owner_e r_rr_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= OWN_CPU;
        end else if (w_cpu_acc) begin
            r_rr_ptr <= OWN_FPU;
        end else if (w_fpu_acc) begin
            r_rr_ptr <= OWN_CPU;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = OWN_CPU;
`endif

    // The one-cycle post-lock CPU turn rides on the CPU starvation input.
    assign w_cpu_starve = (r_cpu_wait == WAIT_W'(MAX_WAIT)) || r_force_cpu;
    assign w_fpu_starve = (r_fpu_wait == WAIT_W'(MAX_WAIT));

    mem_arb_pick u_pick (
        .i_cpu_req    (bus.cpu_req),
        .i_fpu_req    (bus.fpu_req),
        .i_locked     (r_locked),
        .i_cpu_starve (w_cpu_starve),
        .i_fpu_starve (w_fpu_starve),
        .i_rr_ptr     (w_rr_ptr),
        .o_winner     (w_pick)
    );

    assign w_win     = reset ? w_pick : OWN_NONE;
    assign w_cpu_acc = (w_win == OWN_CPU);
    assign w_fpu_acc = (w_win == OWN_FPU);

    always_comb begin
        w_sel = '0;
        unique case (w_win)
            OWN_CPU: begin
                w_sel.we    = bus.cpu_we;
                w_sel.addr  = bus.cpu_addr;
                w_sel.wdata = bus.cpu_wdata;
                w_sel.wstrb = bus.cpu_wstrb;
            end
            OWN_FPU: begin
                w_sel.we    = bus.fpu_we;
                w_sel.addr  = bus.fpu_addr;
                w_sel.wdata = bus.fpu_wdata;
                w_sel.wstrb = bus.fpu_wstrb;
            end
            default: w_sel = '0;
        endcase
    end

    assign bus.cpu_gnt    = w_cpu_acc;
    assign bus.fpu_gnt    = w_fpu_acc;
    assign bus.mem_en     = (w_win != OWN_NONE);
    assign bus.mem_we     = w_sel.we;
    assign bus.mem_addr   = w_sel.addr;
    assign bus.mem_wdata  = w_sel.wdata;
    assign bus.mem_wstrb  = w_sel.wstrb;
    assign bus.cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign bus.fpu_rvalid = (r_rd_owner == OWN_FPU);
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.fpu_rdata  = bus.mem_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_owner <= OWN_NONE;
        end else if (w_cpu_acc && !bus.cpu_we) begin
            r_rd_owner <= OWN_CPU;
        end else if (w_fpu_acc && !bus.fpu_we) begin
            r_rd_owner <= OWN_FPU;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cpu_wait <= '0;
            r_fpu_wait <= '0;
        end else begin
            if (!bus.cpu_req || w_cpu_acc) begin
                r_cpu_wait <= '0;
            end else if (r_cpu_wait != WAIT_W'(MAX_WAIT)) begin
                r_cpu_wait <= r_cpu_wait + 1'b1;
            end
            if (!bus.fpu_req || w_fpu_acc) begin
                r_fpu_wait <= '0;
            end else if (r_fpu_wait != WAIT_W'(MAX_WAIT)) begin
                r_fpu_wait <= r_fpu_wait + 1'b1;
            end
        end
    end

    // The beat that brings lock_cnt to MAX_LOCK releases the lock and hands the CPU the next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_locked    <= 1'b0;
            r_lock_cnt  <= '0;
            r_force_cpu <= 1'b0;
        end else begin
            r_force_cpu <= 1'b0;
            if (!bus.fpu_req) begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end else if (w_fpu_acc) begin
                if (!bus.fpu_lock) begin
                    r_locked   <= 1'b0;
                    r_lock_cnt <= '0;
                end else if ((r_lock_cnt + 1'b1) == LOCK_W'(MAX_LOCK)) begin
                    r_locked    <= 1'b0;
                    r_lock_cnt  <= '0;
                    r_force_cpu <= 1'b1;
                end else begin
                    r_locked   <= 1'b1;
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Directed scoreboard bench for fpu_mem_arbiter; expectations follow FPU_MEM_ARB_RR_EN.
module tb_fpu_mem_arbiter;
    import fpu_mem_pkg::*;

    typedef struct {
        logic        is_fpu;
        logic [31:0] data;
    } sb_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    sb_t         sb[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] tb_mem  [logic [29:0]];
    mem_req_t    cpu_q;
    mem_req_t    fpu_q;
    logic        cpu_on;
    logic        fpu_on;

    fpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    fpu_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (8),
        .MAX_LOCK (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory macro model: registered read, byte-strobed write.
    always @(posedge clock) begin : mem_model
        logic [31:0] word;
        if (bus.mem_en) begin
            word = tb_mem.exists(bus.mem_addr[31:2]) ? tb_mem[bus.mem_addr[31:2]] : 32'h0;
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                tb_mem[bus.mem_addr[31:2]] = word;
            end else begin
                bus.mem_rdata <= word;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

    function automatic mem_req_t rd(input logic [31:0] a);
        return '{we: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'hF};
    endfunction

    function automatic mem_req_t wr(input logic [31:0] a, input logic [31:0] d);
        return '{we: 1'b1, addr: a, wdata: d, wstrb: 4'hF};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input mem_req_t r);
        cpu_on        = req;
        cpu_q         = r;
        bus.cpu_req   = req;
        bus.cpu_we    = r.we;
        bus.cpu_addr  = r.addr;
        bus.cpu_wdata = r.wdata;
        bus.cpu_wstrb = r.wstrb;
    endtask

    task automatic set_fpu(input logic req, input logic lock, input mem_req_t r);
        fpu_on        = req;
        fpu_q         = r;
        bus.fpu_req   = req;
        bus.fpu_lock  = lock;
        bus.fpu_we    = r.we;
        bus.fpu_addr  = r.addr;
        bus.fpu_wdata = r.wdata;
        bus.fpu_wstrb = r.wstrb;
    endtask

    task automatic idle();
        set_cpu(1'b0, rd(32'h0));
        set_fpu(1'b0, 1'b0, rd(32'h0));
    endtask

    task automatic check_resp(input string tag);
        sb_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check({tag, "/cpu_rvalid"}, bus.cpu_rvalid, !it.is_fpu);
            check({tag, "/fpu_rvalid"}, bus.fpu_rvalid, it.is_fpu);
            check({tag, "/rdata"}, it.is_fpu ? bus.fpu_rdata : bus.cpu_rdata, it.data);
        end else begin
            check({tag, "/cpu_rvalid"}, bus.cpu_rvalid, 1'b0);
            check({tag, "/fpu_rvalid"}, bus.fpu_rvalid, 1'b0);
        end
    endtask

    // One access cycle: inputs already driven; ec/ef are the expected grants.
    task automatic beat(input string tag, input logic ec, input logic ef);
        mem_req_t w;
        w = ec ? cpu_q : (ef ? fpu_q : '0);
        #1;
        check({tag, "/cpu_gnt"}, bus.cpu_gnt, ec);
        check({tag, "/fpu_gnt"}, bus.fpu_gnt, ef);
        check({tag, "/mem_en"}, bus.mem_en, ec | ef);
        check({tag, "/mem_fields"}, {bus.mem_we, bus.mem_addr, bus.mem_wstrb},
              {w.we, w.addr, w.wstrb});
        check({tag, "/mem_wdata"}, bus.mem_wdata, w.wdata);
        if (ec || ef) begin
            if (w.we) ref_mem[w.addr[31:2]] = w.wdata;
            else      sb.push_back('{is_fpu: ef, data: ref_rd(w.addr)});
        end
        @(posedge clock);
        @(negedge clock);
        check_resp(tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.mem_rdata = 32'h0;
        reset = 1'b0;
        idle();
        set_cpu(1'b1, rd(32'h1000));
        set_fpu(1'b1, 1'b0, rd(32'h1000));
        repeat (2) @(negedge clock);
        check("rst/cpu_gnt", bus.cpu_gnt, 1'b0);
        check("rst/fpu_gnt", bus.fpu_gnt, 1'b0);
        check("rst/mem_en", bus.mem_en, 1'b0);
        check("rst/cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst/fpu_rvalid", bus.fpu_rvalid, 1'b0);
        idle();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // CPU write then FPU read-back
        set_cpu(1'b1, wr(32'h1000, 32'hDEADBEEF));
        beat("wr_cpu", 1'b1, 1'b0);
        set_cpu(1'b0, rd(32'h0));
        set_fpu(1'b1, 1'b0, rd(32'h1000));
        beat("rd_fpu", 1'b0, 1'b1);

        idle();
        for (int i = 0; i < 10; i++) beat($sformatf("idle%0d", i), 1'b0, 1'b0);

        // FPU write leaves the round-robin pointer on the CPU
        set_fpu(1'b1, 1'b0, wr(32'h2000, 32'h12345678));
        beat("wr_fpu", 1'b0, 1'b1);

        set_cpu(1'b1, rd(32'h1000));
        set_fpu(1'b1, 1'b0, rd(32'h2000));
`ifdef FPU_MEM_ARB_RR_EN
        for (int i = 0; i < 6; i++)
            beat($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
`else
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                beat($sformatf("fix%0d_cpu%0d", r, i), 1'b1, 1'b0);
            beat($sformatf("fix%0d_starved_fpu", r), 1'b0, 1'b1);
        end
`endif
        idle();
        beat("drain0", 1'b0, 1'b0);

        // FPU locked burst against a requesting CPU
        set_fpu(1'b1, 1'b1, wr(32'h3000, 32'hA0A0A0A0));
        beat("lock_b1", 1'b0, 1'b1);
        set_cpu(1'b1, rd(32'h3000));
        set_fpu(1'b1, 1'b1, wr(32'h3004, 32'hA1A1A1A1));
        beat("lock_b2", 1'b0, 1'b1);
        set_fpu(1'b1, 1'b1, wr(32'h3008, 32'hA2A2A2A2));
        beat("lock_b3", 1'b0, 1'b1);
        set_fpu(1'b1, 1'b1, wr(32'h300C, 32'hA3A3A3A3));
        beat("lock_b4", 1'b0, 1'b1);
        set_fpu(1'b1, 1'b1, wr(32'h3010, 32'hA4A4A4A4));
        beat("lock_cpu_turn", 1'b1, 1'b0);
        set_cpu(1'b0, rd(32'h0));
        beat("lock_b5", 1'b0, 1'b1);
        set_fpu(1'b1, 1'b1, wr(32'h3014, 32'hA5A5A5A5));
        beat("lock_b6", 1'b0, 1'b1);
        set_fpu(1'b1, 1'b0, rd(32'h300C));
        beat("lock_rd", 1'b0, 1'b1);
        idle();
        beat("drain1", 1'b0, 1'b0);

        // Reset pulled while a read response is pending
        set_cpu(1'b1, rd(32'h1000));
        #1;
        check("mid_rst/gnt", bus.cpu_gnt, 1'b1);
        @(posedge clock);
        #1;
        check("mid_rst/rvalid_before", bus.cpu_rvalid, 1'b1);
        check("mid_rst/rdata_before", bus.cpu_rdata, 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        check("mid_rst/cpu_rvalid", bus.cpu_rvalid, 1'b0);
        check("mid_rst/fpu_rvalid", bus.fpu_rvalid, 1'b0);
        check("mid_rst/cpu_gnt", bus.cpu_gnt, 1'b0);
        check("mid_rst/mem_en", bus.mem_en, 1'b0);
        idle();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        beat("post_rst0", 1'b0, 1'b0);
        beat("post_rst1", 1'b0, 1'b0);
        set_cpu(1'b1, rd(32'h2000));
        beat("post_rst_req", 1'b1, 1'b0);
        idle();
        beat("drain2", 1'b0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
